cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Stage controller for the 4-bit CPU: drives STAGE (FETCH->DECODE->EXECUTE->WRITEBACK), owns PC and carry flag,
//  handshakes instruction fetch with the ROM, samples decoder OPECODE/imm and issues register/output write strobes.
//  Supports free-run, single-step and halt; detects ROM timeout and INVALID opcodes as a sticky fault.
//  Sits in cpu/ between the ROM port, the decoder, the ALU carry output and the A/B/OUT registers.
// PARAMETERS
//  PC_WIDTH    4   program counter width (ROM depth 2**PC_WIDTH)
//  TIMEOUT     8   max cycles in FETCH waiting for rom_ready before fault (>=1)
//  CNT_WIDTH   16  width of retired-instruction counter
// PORTS
//  clk         in   1          single clock, all state on rising edge
//  rst         in   1          asynchronous, active-high reset
//  run         in   1          level: 1 = free-run, 0 = halt after current instruction
//  step        in   1          1-cycle pulse: execute exactly one instruction while halted
//  rom_ready   in   1          ROM data valid for rom_addr this cycle
//  opecode     in   OPECODE    decoder output (lib_cpu), valid during DECODE
//  imm         in   4          decoder immediate, valid during DECODE
//  carry_in    in   1          ALU carry, valid during EXECUTE
//  stage       out  STAGE      current stage (lib_cpu)
//  rom_req     out  1          fetch request, high only in FETCH
//  rom_addr    out  PC_WIDTH   = pc
//  carry       out  1          carry flag
//  we_a/we_b   out  1 each     register A/B write strobe
//  we_out      out  1          output-port write strobe
//  halted      out  1          high in IDLE
//  fault       out  1          sticky fault
//  retired     out  CNT_WIDTH  instructions completed, wraps
// BEHAVIOUR
//  Reset (async): state IDLE, pc 0, carry 0, op/imm regs 0, all strobes 0, rom_req 0, fault 0, retired 0, stage FETCH.
//  States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FAULT. stage = FETCH in IDLE/FAULT (rom_req low there).
//  IDLE: run=1 or step=1 -> FETCH next cycle; else stay. step outside IDLE is ignored (not queued).
//  FETCH: rom_req=1; rom_ready=1 -> DECODE next cycle, wait counter cleared. Counter counts cycles with
//   rom_ready=0; on TIMEOUT-th such cycle -> FAULT next cycle.
//  DECODE: 1 cycle; registers opecode/imm at cycle end. opecode==INVALID -> FAULT instead of EXECUTE.
//  EXECUTE: 1 cycle; jump decision latched from OLD carry: JMP_IMM always, JNC_IMM iff carry==0.
//   Then carry <= carry_in for ADD_A_IMM/ADD_B_IMM, carry <= 0 for every other opcode.
//  WRITEBACK: 1 cycle; strobes combinational from registered op, high this cycle only:
//   we_a: ADD_A_IMM, MOV_A_IMM, MOV_A_B, IN_A;  we_b: ADD_B_IMM, MOV_B_IMM, MOV_B_A, IN_B;  we_out: OUT_B, OUT_IMM.
//   pc <= jump ? imm : pc+1 (mod 2**PC_WIDTH, 15->0 wraps); retired <= retired+1 (wraps).
//   next: run=1 -> FETCH, else IDLE. run dropped mid-instruction: instruction completes, then IDLE.
//  FAULT: absorbing until rst; fault=1, no strobes, pc/carry frozen.
//  Latency: 4 cycles/instruction with rom_ready tied high; each ROM wait cycle adds 1.
//  Reset mid-instruction aborts it: no strobe, pc unchanged at 0 after reset.
// TESTING
//  T1 rom_ready=1, run=1, ROM[0]=MOV_A_IMM 3: stage F,D,E,W on cycles 1-4; we_a=1 only cycle 4; pc 0->1; retired=1.
//  T2 ADD_A_IMM with carry_in=1, then JNC_IMM 5 -> no jump (pc=2), carry=0 after; next JNC_IMM 5 -> pc=5.
//  T3 pc=15, MOV_B_A -> we_b pulse, pc wraps to 0; JMP_IMM 9 -> pc=9 regardless of carry.
//  T4 run=0, step pulse in IDLE -> exactly one instruction, halted=1 after W; step pulse during EXECUTE ignored.
//  T5 TIMEOUT=8, rom_ready=0 in FETCH -> fault=1 after 8 wait cycles, stays 1; INVALID opcode -> FAULT from DECODE.
//  T6 assert rst during EXECUTE of ADD_A_IMM -> outputs at reset values immediately, no we_a, pc=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// lib_cpu: shared types for the 4-bit CPU (stage and decoded opcode).
// cpu_sequencer: stage controller for the 4-bit CPU.
//   Walks each instruction through FETCH -> DECODE -> EXECUTE -> WRITEBACK.
//   Owns the program counter, the carry flag and the retired-instruction
//   counter. Issues the ROM fetch request and the A/B/OUT register write
//   strobes. Supports free-run, single-step and halt. A ROM that never
//   answers, or an INVALID opcode, parks the sequencer in a sticky FAULT
//   state until reset.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   run           level, 1 = free-run, 0 = halt after current instruction
//   step          1-cycle pulse, runs one instruction when halted
//   rom_ready     ROM data valid for rom_addr this cycle
//   opecode, imm  decoder outputs, sampled at the end of DECODE
//   carry_in      ALU carry, sampled at the end of EXECUTE
//   stage         current pipeline stage (FETCH while idle or faulted)
//   rom_req       fetch request, high only in FETCH
//   rom_addr      program counter
//   carry         carry flag
//   we_a/we_b     register A/B write strobes (WRITEBACK only)
//   we_out        output-port write strobe (WRITEBACK only)
//   halted        high in IDLE
//   fault         sticky fault indicator
//   retired       count of completed instructions, wraps
//   dbg_state     raw FSM state, for observation only
//
// Handshake: rom_req is held high for every cycle spent in FETCH. The fetch
// completes on the first cycle where rom_req and rom_ready are both high;
// rom_ready outside FETCH is ignored. There is no back-pressure on the
// decoder side: opecode/imm must be valid during the single DECODE cycle.
// ---------------------------------------------------------------------------
package lib_cpu;
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } stage_t;

  typedef enum logic [3:0] {
    ADD_A_IMM = 4'h0,
    MOV_A_B   = 4'h1,
    IN_A      = 4'h2,
    MOV_A_IMM = 4'h3,
    MOV_B_A   = 4'h4,
    ADD_B_IMM = 4'h5,
    IN_B      = 4'h6,
    MOV_B_IMM = 4'h7,
    OUT_B     = 4'h9,
    OUT_IMM   = 4'hB,
    INVALID   = 4'hC,
    JNC_IMM   = 4'hE,
    JMP_IMM   = 4'hF
  } opecode_t;
endpackage

module cpu_sequencer
  import lib_cpu::*;
#(
  parameter int PC_WIDTH  = 4,
  parameter int TIMEOUT   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 rom_ready,
  input  opecode_t             opecode,
  input  logic [3:0]           imm,
  input  logic                 carry_in,
  output stage_t               stage,
  output logic                 rom_req,
  output logic [PC_WIDTH-1:0]  rom_addr,
  output logic                 carry,
  output logic                 we_a,
  output logic                 we_b,
  output logic                 we_out,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [2:0]           dbg_state
);

  // Wait counter only has to reach TIMEOUT-1; the TIMEOUT-th idle cycle is
  // recognised by comparison rather than by counting one further.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t                state_q,   state_d;
  logic [PC_WIDTH-1:0]   pc_q,      pc_d;
  logic                  carry_q,   carry_d;
  opecode_t              op_q,      op_d;
  logic [3:0]            imm_q,     imm_d;
  logic                  jump_q,    jump_d;
  logic [WAIT_W-1:0]     wait_q,    wait_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      carry_q   <= 1'b0;
      op_q      <= ADD_A_IMM;
      imm_q     <= '0;
      jump_q    <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      jump_q    <= jump_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    carry_d   = carry_q;
    op_d      = op_q;
    imm_d     = imm_q;
    jump_d    = jump_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    stage     = FETCH;
    rom_req   = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    we_out    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // step only has meaning here; elsewhere it is simply not looked at.
        if (run || step) state_d = S_FETCH;
      end

      S_FETCH: begin
        rom_req = 1'b1;
        if (rom_ready) begin
          state_d = S_DECODE;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        stage   = DECODE;
        op_d    = opecode;
        imm_d   = imm;
        state_d = (opecode == INVALID) ? S_FAULT : S_EXECUTE;
      end

      S_EXECUTE: begin
        stage   = EXECUTE;
        // The jump decision must see the carry left by the previous
        // instruction, so it is taken before carry is overwritten below.
        jump_d  = (op_q == JMP_IMM) || ((op_q == JNC_IMM) && !carry_q);
        carry_d = ((op_q == ADD_A_IMM) || (op_q == ADD_B_IMM)) ? carry_in : 1'b0;
        state_d = S_WRITEBACK;
      end

      S_WRITEBACK: begin
        stage = WRITEBACK;
        case (op_q)
          ADD_A_IMM, MOV_A_IMM, MOV_A_B, IN_A: we_a   = 1'b1;
          ADD_B_IMM, MOV_B_IMM, MOV_B_A, IN_B: we_b   = 1'b1;
          OUT_B, OUT_IMM:                      we_out = 1'b1;
          default: ;
        endcase
        pc_d      = jump_q ? PC_WIDTH'(imm_q) : pc_q + PC_WIDTH'(1);
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end

      S_FAULT: begin
        // Absorbing: only rst leaves this state.
        state_d = S_FAULT;
      end

      default: state_d = S_FAULT;
    endcase
  end

  assign rom_addr  = pc_q;
  assign carry     = carry_q;
  assign halted    = (state_q == S_IDLE);
  assign fault     = (state_q == S_FAULT);
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_sequencer. The bench plays ROM and decoder: it drives
// opecode/imm for the instruction it chooses and checks the sequencer
// against an instruction-level model (pc, carry, retired count, strobes)
// plus the fixed stage timeline of one instruction.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;
  import lib_cpu::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic        rom_ready;
  opecode_t    opecode;
  logic [3:0]  imm;
  logic        carry_in;
  stage_t      stage;
  logic        rom_req;
  logic [3:0]  rom_addr;
  logic        carry;
  logic        we_a;
  logic        we_b;
  logic        we_out;
  logic        halted;
  logic        fault;
  logic [15:0] retired;
  logic [2:0]  dbg_state;

  cpu_sequencer #(.PC_WIDTH(4), .TIMEOUT(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .rom_ready (rom_ready),
    .opecode   (opecode),
    .imm       (imm),
    .carry_in  (carry_in),
    .stage     (stage),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .carry     (carry),
    .we_a      (we_a),
    .we_b      (we_b),
    .we_out    (we_out),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- scoreboard / reference model state ----
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  m_pc;
  logic        m_carry;
  logic [15:0] m_ret;
  bit          m_idle;
  logic [2:0]  exp_q[$];   // expected {we_a,we_b,we_out} of pending instruction

  opecode_t valid_ops[12] = '{ADD_A_IMM, MOV_A_B, IN_A, MOV_A_IMM, MOV_B_A, ADD_B_IMM,
                              IN_B, MOV_B_IMM, OUT_B, OUT_IMM, JNC_IMM, JMP_IMM};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] strobes_for(input opecode_t op);
    case (op)
      ADD_A_IMM, MOV_A_IMM, MOV_A_B, IN_A: return 3'b100;
      ADD_B_IMM, MOV_B_IMM, MOV_B_A, IN_B: return 3'b010;
      OUT_B, OUT_IMM:                      return 3'b001;
      default:                             return 3'b000;
    endcase
  endfunction

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    run       = 1'b0;
    step      = 1'b0;
    rom_ready = 1'b0;
    carry_in  = 1'b0;
    opecode   = ADD_A_IMM;
    imm       = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_pc    = 4'h0;
    m_carry = 1'b0;
    m_ret   = 16'h0;
    m_idle  = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_stage"},   stage, FETCH);
    chk({tag, "_rom_req"}, rom_req, 1'b0);
    chk({tag, "_pc"},      rom_addr, 4'h0);
    chk({tag, "_carry"},   carry, 1'b0);
    chk({tag, "_we"},      {we_a, we_b, we_out}, 3'b000);
    chk({tag, "_halted"},  halted, 1'b1);
    chk({tag, "_fault"},   fault, 1'b0);
    chk({tag, "_retired"}, retired, 16'h0);
  endtask

  // Runs one complete instruction.
  // mode 0: free-run (run=1 throughout)
  // mode 1: free-run start, run dropped during DECODE -> halts after it
  // mode 2: single step from IDLE, with a stray step pulse in EXECUTE
  task automatic run_instr(input opecode_t op, input logic [3:0] im, input int waits,
                           input logic cin, input int mode);
    bit         jump;
    logic [2:0] exp_we;
    if (m_idle) begin
      if (mode == 2) step = 1'b1;
      else           run  = 1'b1;
      tick();
      step = 1'b0;
    end
    // FETCH, with ROM wait cycles first
    rom_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("fetch_wait_stage", stage, FETCH);
      chk("fetch_wait_req", rom_req, 1'b1);
      tick();
    end
    rom_ready = 1'b1;
    opecode   = op;
    imm       = im;
    chk("fetch_stage", stage, FETCH);
    chk("fetch_req", rom_req, 1'b1);
    chk("fetch_addr", rom_addr, m_pc);
    chk("fetch_halted", halted, 1'b0);
    tick();
    rom_ready = 1'(($urandom_range(0, 1)));
    // DECODE
    chk("decode_stage", stage, DECODE);
    chk("decode_req", rom_req, 1'b0);
    if (mode == 1) run = 1'b0;
    carry_in = cin;
    tick();
    // EXECUTE: decoder outputs are no longer valid, scramble them
    chk("exec_stage", stage, EXECUTE);
    chk("exec_we", {we_a, we_b, we_out}, 3'b000);
    opecode = opecode_t'(4'($urandom_range(0, 15)));
    imm     = 4'($urandom_range(0, 15));
    if (mode == 2) step = 1'b1;
    tick();
    step     = 1'b0;
    carry_in = 1'($urandom_range(0, 1));
    // model: jump from old carry, then carry update, then pc/retired
    jump    = (op == JMP_IMM) || (op == JNC_IMM && m_carry == 1'b0);
    m_carry = (op == ADD_A_IMM || op == ADD_B_IMM) ? cin : 1'b0;
    exp_q.push_back(strobes_for(op));
    // WRITEBACK
    exp_we = exp_q.pop_front();
    chk("wb_stage", stage, WRITEBACK);
    chk("wb_we", {we_a, we_b, we_out}, exp_we);
    chk("wb_carry", carry, m_carry);
    m_pc   = jump ? im : m_pc + 4'h1;
    m_ret  = m_ret + 16'h1;
    m_idle = (mode != 0);
    tick();
    chk("post_pc", rom_addr, m_pc);
    chk("post_retired", retired, m_ret);
    chk("post_carry", carry, m_carry);
    chk("post_halted", halted, m_idle);
    chk("post_stage", stage, FETCH);
    chk("post_we", {we_a, we_b, we_out}, 3'b000);
  endtask

  // ---- main sequence ----
  initial begin
    rst = 1'b1;
    reset_dut();
    check_reset_state("reset");
    tick();
    chk("idle_hold", halted, 1'b1);

    // T1: first instruction, 4-cycle latency
    run_instr(MOV_A_IMM, 4'd3, 0, 1'b0, 0);
    // T2: carry from ADD, JNC sees it, then JNC jumps once carry cleared
    run_instr(ADD_A_IMM, 4'd7, 0, 1'b1, 0);
    chk("t2_carry_set", carry, 1'b1);
    run_instr(JNC_IMM, 4'd5, 0, 1'b0, 0);
    chk("t2_no_jump_pc", rom_addr, 4'd3);
    chk("t2_carry_clr", carry, 1'b0);
    run_instr(JNC_IMM, 4'd5, 0, 1'b0, 0);
    chk("t2_jump_pc", rom_addr, 4'd5);
    // T3: pc wrap and unconditional jump with carry set
    run_instr(JMP_IMM, 4'd15, 1, 1'b0, 0);
    run_instr(MOV_B_A, 4'd0, 2, 1'b0, 0);
    chk("t3_wrap_pc", rom_addr, 4'd0);
    run_instr(ADD_B_IMM, 4'd1, 0, 1'b1, 0);
    run_instr(JMP_IMM, 4'd9, 0, 1'b0, 0);
    chk("t3_jmp_pc", rom_addr, 4'd9);
    // longest legal ROM wait without faulting
    run_instr(OUT_IMM, 4'd2, 7, 1'b0, 0);
    chk("max_wait_no_fault", fault, 1'b0);
    // T4: drop run mid-instruction, then single step with stray step
    run_instr(OUT_B, 4'd0, 0, 1'b0, 1);
    run_instr(IN_A, 4'd0, 0, 1'b0, 2);
    repeat (3) tick();
    chk("t4_step_not_queued", halted, 1'b1);
    chk("t4_pc_stable", rom_addr, m_pc);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      int mode;
      mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      if (!m_idle && mode == 2) mode = 0;
      run_instr(valid_ops[$urandom_range(0, 11)], 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), mode);
    end

    // T6: reset during EXECUTE of ADD_A_IMM
    reset_dut();
    run = 1'b1;
    tick();
    rom_ready = 1'b1;
    opecode   = ADD_A_IMM;
    imm       = 4'd4;
    carry_in  = 1'b1;
    tick();
    tick();
    chk("t6_in_exec", stage, EXECUTE);
    rst = 1'b1;
    run = 1'b0;
    #1;
    check_reset_state("t6_async");
    tick();
    chk("t6_no_we_a", we_a, 1'b0);
    reset_dut();
    check_reset_state("t6_after");

    // T5a: ROM timeout after exactly 8 wait cycles
    run       = 1'b1;
    rom_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t5_wait_no_fault", fault, 1'b0);
      chk("t5_wait_stage", stage, FETCH);
      tick();
    end
    chk("t5_timeout_fault", fault, 1'b1);
    rom_ready = 1'b1;
    step      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_fault_sticky", fault, 1'b1);
      chk("t5_fault_req", rom_req, 1'b0);
      chk("t5_fault_we", {we_a, we_b, we_out}, 3'b000);
      chk("t5_fault_pc", rom_addr, 4'h0);
      chk("t5_fault_stage", stage, FETCH);
    end
    step = 1'b0;

    // T5b: INVALID opcode faults from DECODE
    reset_dut();
    run = 1'b1;
    tick();
    rom_ready = 1'b1;
    opecode   = INVALID;
    tick();
    chk("t5_inv_decode", stage, DECODE);
    tick();
    chk("t5_inv_fault", fault, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_inv_sticky", fault, 1'b1);
      chk("t5_inv_we", {we_a, we_b, we_out}, 3'b000);
      chk("t5_inv_retired", retired, 16'h0);
      chk("t5_inv_halted", halted, 1'b0);
    end

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
